// File: rtl/gamepad_pmod_transmitter.sv
// Gamepad Pmod serial transmitter: serialises the button vector onto latch/clk/data, MSB first.
// Define GAMEPAD_TX_DUAL_EN to add buttons_b and send 24-bit two-controller frames.
module gamepad_pmod_transmitter #(
  parameter int CLK_DIV   = 4,
  parameter int FRAME_GAP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [11:0] buttons,
`ifdef GAMEPAD_TX_DUAL_EN
  input  logic [11:0] buttons_b,
`endif
  output logic        pmod_latch,
  output logic        pmod_clk,
  output logic        pmod_data,
  output logic        busy,
  output logic        frame_done
);

`ifdef GAMEPAD_TX_DUAL_EN
  localparam int NBITS = 24;
`else
  localparam int NBITS = 12;
`endif

  // One phase counter serves both the clock half-periods and the inter-frame gap.
  localparam int PH_MAX = (CLK_DIV > FRAME_GAP) ? CLK_DIV : FRAME_GAP;
  localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int BIT_W  = $clog2(NBITS + 1);

  localparam logic [PH_W-1:0]  DIV_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [PH_W-1:0]  GAP_LAST = PH_W'((FRAME_GAP > 0) ? FRAME_GAP - 1 : 0);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    LATCH    = 3'd3,
    GAP      = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [PH_W-1:0]    phase_q, phase_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic               latch_q, latch_d;
  logic               pclk_q, pclk_d;
  logic               data_q, data_d;
  logic               done_q, done_d;
  logic [NBITS-1:0]   load_word;

`ifdef GAMEPAD_TX_DUAL_EN
  assign load_word = {buttons_b, buttons};
`else
  assign load_word = buttons;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      phase_q <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      latch_q <= 1'b0;
      pclk_q  <= 1'b0;
      data_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      latch_q <= latch_d;
      pclk_q  <= pclk_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    latch_d = latch_q;
    pclk_d  = pclk_q;
    data_d  = data_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        latch_d = 1'b0;
        pclk_d  = 1'b0;
        data_d  = 1'b0;
        phase_d = '0;
        bit_d   = '0;
        // Buttons are snapshotted here; the first bit is driven on the same edge.
        if (enable) begin
          state_d = SHIFT_LO;
          shreg_d = load_word;
          data_d  = load_word[NBITS-1];
        end
      end

      SHIFT_LO: begin
        if (phase_q == DIV_LAST) begin
          state_d = SHIFT_HI;
          phase_d = '0;
          pclk_d  = 1'b1;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      SHIFT_HI: begin
        // Data only moves on the falling clock transition, never on the rising one.
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          pclk_d  = 1'b0;
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == BIT_LAST) begin
            state_d = LATCH;
            data_d  = 1'b0;
            latch_d = 1'b1;
          end else begin
            state_d = SHIFT_LO;
            data_d  = shreg_q[NBITS-2];
          end
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      LATCH: begin
        if (phase_q == DIV_LAST) begin
          phase_d = '0;
          latch_d = 1'b0;
          done_d  = 1'b1;
          state_d = (FRAME_GAP == 0) ? IDLE : GAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      GAP: begin
        if (phase_q == GAP_LAST) begin
          phase_d = '0;
          state_d = IDLE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
        phase_d = '0;
      end
    endcase
  end

  assign pmod_latch = latch_q;
  assign pmod_clk   = pclk_q;
  assign pmod_data  = data_q;
  assign frame_done = done_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_gamepad_pmod_transmitter.sv
// Bench for gamepad_pmod_transmitter: time-based frame model, 12-bit shift receiver model,
// and directed vectors on a default instance and a CLK_DIV=1/FRAME_GAP=0 instance.
module tb_gamepad_pmod_transmitter;
  localparam int CD = 4;
  localparam int FG = 8;
`ifdef GAMEPAD_TX_DUAL_EN
  localparam int NB = 24;
  localparam int EXP_PERIOD1  = 205;
  localparam int EXP_DONE_OFS = 197;
  localparam int EXP_PERIOD2  = 50;
`else
  localparam int NB = 12;
  localparam int EXP_PERIOD1  = 109;
  localparam int EXP_DONE_OFS = 101;
  localparam int EXP_PERIOD2  = 26;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en1 = 1'b0, en2 = 1'b0;
  logic [11:0] btn1 = '0, btn2 = '0, btnb = '0;
  logic lat1, pc1, pd1, bz1, dn1;
  logic lat2, pc2, pd2, bz2, dn2;

  always #5 clk = ~clk;

  gamepad_pmod_transmitter #(.CLK_DIV(CD), .FRAME_GAP(FG)) dut (
    .clk(clk), .rst_n(rst_n), .enable(en1), .buttons(btn1),
`ifdef GAMEPAD_TX_DUAL_EN
    .buttons_b(btnb),
`endif
    .pmod_latch(lat1), .pmod_clk(pc1), .pmod_data(pd1), .busy(bz1), .frame_done(dn1)
  );

  gamepad_pmod_transmitter #(.CLK_DIV(1), .FRAME_GAP(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(en2), .buttons(btn2),
`ifdef GAMEPAD_TX_DUAL_EN
    .buttons_b(btnb),
`endif
    .pmod_latch(lat2), .pmod_clk(pc2), .pmod_data(pd2), .busy(bz2), .frame_done(dn2)
  );

  int vec = 0;
  int fails = 0;
  int cyc = 0;
  bit chk_on = 1'b0;

  // Frame model: k = cycles since the frame-start edge, -1 when idle.
  int k1 = -1, k2 = -1;
  logic [23:0] w1 = '0, w2 = '0;

  function automatic logic [4:0] expv(int k, logic [23:0] w, int cd, int fg);
    logic [4:0] v;
    int l0, p;
    l0 = 2 * cd * NB;
    p  = l0 + cd + fg + 1;
    v  = '0;
    if (k >= 0 && k < l0) begin
      v[3] = ((k % (2 * cd)) >= cd);
      v[2] = w[NB - 1 - k / (2 * cd)];
    end
    if (k >= l0 && k < l0 + cd) v[4] = 1'b1;
    if (k == l0 + cd) v[0] = 1'b1;
    if (k >= 0 && k < p - 1) v[1] = 1'b1;
    return v;
  endfunction

  function automatic int nextk(int k, int cd, int fg, logic rn, logic en);
    int p;
    p = 2 * cd * NB + cd + fg + 1;
    if (!rn) return -1;
    if (k < 0 || k == p - 1) return en ? 0 : -1;
    return k + 1;
  endfunction

  function automatic logic [23:0] snap(logic [11:0] b);
`ifdef GAMEPAD_TX_DUAL_EN
    return {btnb, b};
`else
    return {12'h000, b};
`endif
  endfunction

  always @(posedge clk) begin
    int n;
    cyc = cyc + 1;
    n = nextk(k1, CD, FG, rst_n, en1);
    if (n == 0) w1 = snap(btn1);
    k1 = n;
    n = nextk(k2, 1, 0, rst_n, en2);
    if (n == 0) w2 = snap(btn2);
    k2 = n;
  end

  // Receiver model and event recording
  logic [23:0] rx_sh = '0, rx_all = '0;
  logic [11:0] rx12 = '0;
  int rises = 0, last_rises = 0, lat_len = 0, last_lat_len = 0;
  int done_cnt = 0, done_t = 0;
  int done2_cnt = 0, done2_t = 0, prev_done2_t = 0;
  int bad2 = 0, nogap_bad = 0;
  logic prev_pc1 = 1'b0, prev_pd1 = 1'b0, prev_lat1 = 1'b0, prev_pc2 = 1'b0, prev_pd2 = 1'b0;

  always @(negedge clk) begin
    logic [4:0] a1, a2, e1, e2;
    a1 = {lat1, pc1, pd1, bz1, dn1};
    a2 = {lat2, pc2, pd2, bz2, dn2};
    if (chk_on) begin
      e1 = expv(k1, w1, CD, FG);
      e2 = expv(k2, w2, 1, 0);
      vec++;
      if (a1 !== e1) begin
        fails++;
        $display("FAIL model_dut1 cyc=%0d latch/clk/data/busy/done got=%b want=%b", cyc, a1, e1);
      end
      vec++;
      if (a2 !== e2) begin
        fails++;
        $display("FAIL model_dut2 cyc=%0d latch/clk/data/busy/done got=%b want=%b", cyc, a2, e2);
      end
      if (pc1 && !prev_pc1) begin
        vec++;
        if (pd1 !== prev_pd1) begin
          fails++;
          $display("FAIL data_at_rise_dut1 cyc=%0d got=%b want=%b", cyc, pd1, prev_pd1);
        end
      end
      if (pc2 && !prev_pc2) begin
        vec++;
        if (pd2 !== prev_pd2) begin
          fails++;
          $display("FAIL data_at_rise_dut2 cyc=%0d got=%b want=%b", cyc, pd2, prev_pd2);
        end
      end
    end
    if (!rst_n) begin
      rises = 0;
      lat_len = 0;
    end else begin
      if (pc1 && !prev_pc1) begin
        rx_sh = {rx_sh[22:0], pd1};
        rises++;
      end
      if (lat1) lat_len++;
      if (!lat1 && prev_lat1) begin
        last_lat_len = lat_len;
        lat_len = 0;
      end
      if (lat1 && !prev_lat1) begin
        rx12 = rx_sh[11:0];
        rx_all = rx_sh;
        last_rises = rises;
        rises = 0;
      end
      if (dn1 === 1'b1) begin
        done_cnt++;
        done_t = cyc;
      end
      if (dn2 === 1'b1) begin
        prev_done2_t = done2_t;
        done2_t = cyc;
        done2_cnt++;
        if (bz2 !== 1'b0) nogap_bad++;
      end
      if (bz2 === 1'b1 && lat2 === 1'b0 && dn2 === 1'b0 && pd2 !== 1'b1 && btn2 == 12'hFFF) bad2++;
    end
    prev_pc1 = pc1; prev_pd1 = pd1; prev_lat1 = lat1;
    prev_pc2 = pc2; prev_pd2 = pd2;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic drive();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int want);
    vec++;
    if (got != want) begin
      fails++;
      $display("FAIL %s got=%0d (0x%0h) want=%0d (0x%0h)", name, got, got, want, want);
    end
  endtask

  task automatic wait_done1(input int maxc);
    int n0, i;
    n0 = done_cnt;
    i = 0;
    while (done_cnt == n0 && i < maxc) begin
      tick();
      i++;
    end
    if (done_cnt == n0) begin
      vec++;
      fails++;
      $display("FAIL wait_frame_done timeout got=none within %0d cycles want=pulse", maxc);
    end
  endtask

  task automatic wait_done2(input int maxc);
    int n0, i;
    n0 = done2_cnt;
    i = 0;
    while (done2_cnt == n0 && i < maxc) begin
      tick();
      i++;
    end
    if (done2_cnt == n0) begin
      vec++;
      fails++;
      $display("FAIL wait_frame_done2 timeout got=none within %0d cycles want=pulse", maxc);
    end
  endtask

  task automatic wait_idle1(input int maxc);
    int i;
    i = 0;
    while (bz1 !== 1'b0 && i < maxc) begin
      tick();
      i++;
    end
    if (bz1 !== 1'b0) begin
      vec++;
      fails++;
      $display("FAIL wait_busy_low timeout got=%b want=0", bz1);
    end
  endtask

  initial begin
    int c0, t1, d0, i;
    // Reset state
    rst_n = 1'b0;
    repeat (3) drive();
    tick();
    chk("reset_latch", lat1, 0);
    chk("reset_pclk", pc1, 0);
    chk("reset_data", pd1, 0);
    chk("reset_busy", bz1, 0);
    chk("reset_done", dn1, 0);
    chk("reset_dut2_all", {lat2, pc2, pd2, bz2, dn2}, 0);
    chk_on = 1'b1;
    drive();
    rst_n = 1'b1;
    repeat (3) drive();

    // Single frame with a one-cycle enable pulse
    btn1 = 12'hA5C;
    drive();
    en1 = 1'b1;
    c0 = cyc;
    d0 = done_cnt;
    drive();
    en1 = 1'b0;
    wait_done1(400);
    chk("single_bits", rx12, 12'hA5C);
    chk("single_rises", last_rises, NB);
    chk("single_latch_len", last_lat_len, CD);
    chk("single_done_offset", done_t - c0, EXP_DONE_OFS);
    t1 = done_t;
    wait_idle1(50);
    chk("single_busy_fall", cyc - t1, FG);
    repeat (150) tick();
    chk("single_done_once", done_cnt - d0, 1);

    // Reset mid-frame, then a fresh frame
    btn1 = 12'h3C9;
    drive();
    en1 = 1'b1;
    i = 0;
    while (rises != 5 && i < 400) begin
      tick();
      i++;
    end
    chk("reach_bit5", rises, 5);
    drive();
    rst_n = 1'b0;
    drive();
    rst_n = 1'b1;
    tick();
    chk("midreset_outputs", {lat1, pc1, pd1, dn1}, 0);
    chk("midreset_busy", bz1, 0);
    wait_done1(400);
    chk("after_reset_bits", rx12, 12'h3C9);
    chk("after_reset_rises", last_rises, NB);
    drive();
    en1 = 1'b0;
    wait_idle1(50);

    // Loopback with enable held high, mid-frame button change
    drive();
    btn1 = 12'h0F1;
    en1 = 1'b1;
    wait_done1(400);
    chk("loop_first", rx12, 12'h0F1);
    t1 = done_t;
    repeat (30) tick();
    drive();
    btn1 = 12'h800;
    wait_done1(400);
    chk("loop_ignore_change", rx12, 12'h0F1);
    chk("loop_period_a", done_t - t1, EXP_PERIOD1);
    t1 = done_t;
    wait_done1(400);
    chk("loop_new_value", rx12, 12'h800);
    chk("loop_period_b", done_t - t1, EXP_PERIOD1);
    drive();
    en1 = 1'b0;
    wait_idle1(50);

`ifdef GAMEPAD_TX_DUAL_EN
    // Two-controller frame
    drive();
    btnb = 12'h123;
    btn1 = 12'h456;
    en1 = 1'b1;
    drive();
    en1 = 1'b0;
    wait_done1(400);
    chk("dual_stream", rx_all, 24'h123456);
    chk("dual_rx12", rx12, 12'h456);
    chk("dual_rises", last_rises, 24);
    wait_idle1(50);
    btnb = 12'hFFF;
`endif

    // Parameter corner: CLK_DIV=1, FRAME_GAP=0, all buttons pressed
    drive();
    btn2 = 12'hFFF;
    en2 = 1'b1;
    wait_done2(200);
    wait_done2(200);
    chk("corner_period_a", done2_t - prev_done2_t, EXP_PERIOD2);
    wait_done2(200);
    chk("corner_period_b", done2_t - prev_done2_t, EXP_PERIOD2);
    drive();
    en2 = 1'b0;
    repeat (60) tick();
    chk("corner_data_high", bad2, 0);
    chk("corner_no_gap", nogap_bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end
endmodule
